// File: rtl/imem_responder.sv
// Instruction fetch responder: a halfword memory that returns 16-bit or 32-bit instructions for a PC.
// Latency: RD_LAT+1 cycles (16-bit) or 2*RD_LAT+1 cycles (32-bit) from the request cycle to resp_valid.
// Backpressure: one request in flight; req_ready is low while busy or flushing; responses cannot be stalled.
// Optional boot sequence (reset vector fetched from mem[0..1]) is compiled in by defining IMEM_BOOT_EN.
module imem_responder #(
    parameter int AW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req_valid,
    input  logic [31:0]   i_req_addr,
    output logic          o_req_ready,
    input  logic          i_flush,
    output logic          o_resp_valid,
    output logic [31:0]   o_resp_instr,
    output logic          o_resp_size,
    output logic [31:0]   o_resp_next_pc,
    input  logic          i_ld_en,
    input  logic [AW-1:0] i_ld_addr,
    input  logic [15:0]   i_ld_data,
    output logic [31:0]   o_reset_vec,
    output logic          o_boot_done
);

    localparam int         DEPTH    = 1 << AW;
    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
`ifdef IMEM_BOOT_EN
        S_BOOT0 = 3'd0,
        S_BOOT1 = 3'd1,
`endif
        S_IDLE  = 3'd2,
        S_RD0   = 3'd3,
        S_RD1   = 3'd4,
        S_RESP  = 3'd5
    } state_t;

`ifdef IMEM_BOOT_EN
    localparam state_t RST_STATE = S_BOOT0;
`else
    localparam state_t RST_STATE = S_IDLE;
`endif

    logic [15:0]   r_mem [0:DEPTH-1];

    state_t        r_state;
    state_t        w_nxt;
    logic [1:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_pc;
    logic [15:0]   r_hw0;
    logic [15:0]   r_hw1;
    logic [31:0]   r_resp_instr;
    logic          r_resp_size;
    logic [31:0]   r_resp_next_pc;
    logic          r_boot_done;

    logic [AW-1:0] w_rd_addr;
    logic [15:0]   w_rd_dat;
    logic          w_rd_end;
    logic          w_accept;
    logic          w_req_ready;
    logic          w_resp_valid;
    logic          w_cur_size;
    logic [31:0]   w_cur_instr;
    logic [31:0]   w_cur_next_pc;

    // Loader write port; the array is deliberately left out of reset so images can be loaded under reset.
    always_ff @(posedge i_clk) begin
        if (i_ld_en) begin
            r_mem[i_ld_addr] <= i_ld_data;
        end
    end

    // Read address follows the state; the asynchronous read is captured at the edge, so a same-edge write yields old data.
    always_comb begin
        w_rd_addr = r_addr;
        case (r_state)
`ifdef IMEM_BOOT_EN
            S_BOOT0: w_rd_addr = '0;
            S_BOOT1: w_rd_addr = AW'(1);
`endif
            S_RD1:   w_rd_addr = r_addr + AW'(1);
            default: w_rd_addr = r_addr;
        endcase
    end

    assign w_rd_dat = r_mem[w_rd_addr];
    assign w_rd_end = (r_cnt == 2'd0);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // Next-state and handshake outputs; flush kills any in-flight fetch and masks a pending response.
    always_comb begin
        w_nxt        = r_state;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
`ifdef IMEM_BOOT_EN
            S_BOOT0: w_nxt = S_BOOT1;
            S_BOOT1: w_nxt = S_IDLE;
`endif
            S_IDLE: begin
                w_req_ready = !i_flush;
                w_accept    = i_req_valid && !i_flush;
                if (w_accept) begin
                    w_nxt = S_RD0;
                end
            end
            S_RD0: begin
                if (i_flush) begin
                    w_nxt = S_IDLE;
                end else if (w_rd_end) begin
                    w_nxt = w_rd_dat[15] ? S_RD1 : S_RESP;
                end
            end
            S_RD1: begin
                if (i_flush) begin
                    w_nxt = S_IDLE;
                end else if (w_rd_end) begin
                    w_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_resp_valid = !i_flush;
                w_nxt        = S_IDLE;
            end
            default: w_nxt = RST_STATE;
        endcase
    end

    // Read-phase down-counter: reloaded on entry to a read state, so each read state spans RD_LAT cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 2'd0;
        end else if ((w_nxt == S_RD0 || w_nxt == S_RD1) && (w_nxt != r_state)) begin
            r_cnt <= CNT_INIT;
        end else if (r_cnt != 2'd0) begin
            r_cnt <= r_cnt - 2'd1;
        end
    end

    // Response fields are formed from the captured halfwords; bit 15 of the first halfword marks a 32-bit instruction.
    assign w_cur_size    = r_hw0[15];
    assign w_cur_instr   = {r_hw0, (w_cur_size ? r_hw1 : 16'h0000)};
    assign w_cur_next_pc = r_pc + (w_cur_size ? 32'd2 : 32'd1);

    // Request latch, halfword capture, response hold registers and boot bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr         <= '0;
            r_pc           <= 32'd0;
            r_hw0          <= 16'd0;
            r_hw1          <= 16'd0;
            r_resp_instr   <= 32'd0;
            r_resp_size    <= 1'b0;
            r_resp_next_pc <= 32'd0;
            r_boot_done    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= i_req_addr[AW-1:0];
                r_pc   <= i_req_addr;
            end
            if (r_state == S_RD0 && !i_flush && w_rd_end) begin
                r_hw0 <= w_rd_dat;
            end
            if (r_state == S_RD1 && !i_flush && w_rd_end) begin
                r_hw1 <= w_rd_dat;
            end
            // Keep the last presented response so the outputs hold once RESP is left.
            if (r_state == S_RESP) begin
                r_resp_instr   <= w_cur_instr;
                r_resp_size    <= w_cur_size;
                r_resp_next_pc <= w_cur_next_pc;
            end
`ifdef IMEM_BOOT_EN
            if (r_state == S_BOOT1) begin
                r_boot_done <= 1'b1;
            end
`else
            r_boot_done <= 1'b1;
`endif
        end
    end

`ifdef IMEM_BOOT_EN
    logic [31:0] r_reset_vec;

    // Reset vector is assembled high halfword first from mem[0], then mem[1].
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_reset_vec <= 32'd0;
        end else if (r_state == S_BOOT0) begin
            r_reset_vec[31:16] <= w_rd_dat;
        end else if (r_state == S_BOOT1) begin
            r_reset_vec[15:0] <= w_rd_dat;
        end
    end

    assign o_reset_vec = r_reset_vec;
`else
    assign o_reset_vec = 32'd0;
`endif

    assign o_req_ready    = w_req_ready;
    assign o_resp_valid   = w_resp_valid;
    assign o_resp_instr   = (r_state == S_RESP) ? w_cur_instr   : r_resp_instr;
    assign o_resp_size    = (r_state == S_RESP) ? w_cur_size    : r_resp_size;
    assign o_resp_next_pc = (r_state == S_RESP) ? w_cur_next_pc : r_resp_next_pc;
    assign o_boot_done    = r_boot_done;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder (AW=8, RD_LAT=1) against a halfword-array reference model.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Works with or without IMEM_BOOT_EN defined.
module tb_imem_responder;

    localparam int AW     = 8;
    localparam int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [31:0]   req_addr;
    logic          req_ready;
    logic          flush;
    logic          resp_valid;
    logic [31:0]   resp_instr;
    logic          resp_size;
    logic [31:0]   resp_next_pc;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [15:0]   ld_data;
    logic [31:0]   reset_vec;
    logic          boot_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] model_mem [0:255];

`ifdef IMEM_BOOT_EN
    localparam logic BOOT = 1'b1;
`else
    localparam logic BOOT = 1'b0;
`endif

    always #5 clk = ~clk;

    imem_responder #(.AW(AW), .RD_LAT(RD_LAT)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .i_req_addr     (req_addr),
        .o_req_ready    (req_ready),
        .i_flush        (flush),
        .o_resp_valid   (resp_valid),
        .o_resp_instr   (resp_instr),
        .o_resp_size    (resp_size),
        .o_resp_next_pc (resp_next_pc),
        .i_ld_en        (ld_en),
        .i_ld_addr      (ld_addr),
        .i_ld_data      (ld_data),
        .o_reset_vec    (reset_vec),
        .o_boot_done    (boot_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en = 1'b0;
        model_mem[a] = d;
    endtask

    // Reference: fetch result straight from the instruction-format rules.
    function automatic void ref_fetch(input logic [31:0] pc, output logic [31:0] instr,
                                      output logic size, output logic [31:0] npc, output int lat);
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [15:0] h0;
        logic [15:0] h1;
        a0    = pc[7:0];
        a1    = a0 + 8'd1;
        h0    = model_mem[a0];
        h1    = model_mem[a1];
        size  = h0[15];
        instr = size ? {h0, h1} : {h0, 16'h0000};
        npc   = pc + (size ? 32'd2 : 32'd1);
        lat   = size ? (2 * RD_LAT + 1) : (RD_LAT + 1);
    endfunction

    // Issue one request and watch for the response; lat counts cycles from the request cycle.
    task automatic fetch(input logic [31:0] pc, output bit got, output int lat,
                         output logic [31:0] instr, output logic size, output logic [31:0] npc);
        int w;
        got = 1'b0; lat = 0; instr = '0; size = 1'b0; npc = '0;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        req_valid = 1'b1;
        req_addr  = pc;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (resp_valid === 1'b1) begin
                got = 1'b1; lat = c; instr = resp_instr; size = resp_size; npc = resp_next_pc;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        #2;
        load(8'h00, 16'h0000);
        load(8'h01, 16'h0040);
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        n_cmp++; if (resp_instr !== 32'h0) begin n_err++; $display("FAIL rst_resp_instr: got %h want 0", resp_instr); end
        n_cmp++; if (resp_size !== 1'b0) begin n_err++; $display("FAIL rst_resp_size: got %b want 0", resp_size); end
        n_cmp++; if (resp_next_pc !== 32'h0) begin n_err++; $display("FAIL rst_next_pc: got %h want 0", resp_next_pc); end
        n_cmp++; if (boot_done !== 1'b0) begin n_err++; $display("FAIL rst_boot_done: got %b want 0", boot_done); end
        n_cmp++; if (reset_vec !== 32'h0) begin n_err++; $display("FAIL rst_reset_vec: got %h want 0", reset_vec); end
        n_cmp++; if (req_ready !== !BOOT) begin n_err++; $display("FAIL rst_req_ready: got %b want %b", req_ready, !BOOT); end
        rst_n = 1'b1;
        tick();
        if (BOOT) begin
            n_cmp++; if (boot_done !== 1'b0) begin n_err++; $display("FAIL boot1_done: got %b want 0", boot_done); end
            n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL boot1_ready: got %b want 0", req_ready); end
            tick();
            n_cmp++; if (reset_vec !== 32'h00000040) begin n_err++; $display("FAIL boot_vec: got %h want 00000040", reset_vec); end
        end else begin
            n_cmp++; if (reset_vec !== 32'h0) begin n_err++; $display("FAIL noboot_vec: got %h want 0", reset_vec); end
        end
        n_cmp++; if (boot_done !== 1'b1) begin n_err++; $display("FAIL boot_done: got %b want 1", boot_done); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL idle_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_16bit();
        bit got; int lat; logic [31:0] ins; logic sz; logic [31:0] npc;
        load(8'h10, 16'h1234);
        fetch(32'h10, got, lat, ins, sz, npc);
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL 16b_got: got %b want 1", got); end
        n_cmp++; if (lat != 2) begin n_err++; $display("FAIL 16b_lat: got %0d want 2", lat); end
        n_cmp++; if (ins !== 32'h12340000) begin n_err++; $display("FAIL 16b_instr: got %h want 12340000", ins); end
        n_cmp++; if (sz !== 1'b0) begin n_err++; $display("FAIL 16b_size: got %b want 0", sz); end
        n_cmp++; if (npc !== 32'h11) begin n_err++; $display("FAIL 16b_npc: got %h want 00000011", npc); end
        tick();
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL 16b_pulse: got %b want 0", resp_valid); end
        n_cmp++; if (resp_instr !== 32'h12340000) begin n_err++; $display("FAIL 16b_hold: got %h want 12340000", resp_instr); end
    endtask

    task automatic test_32bit();
        bit got; int lat; logic [31:0] ins; logic sz; logic [31:0] npc;
        load(8'h20, 16'h8A00);
        load(8'h21, 16'h00FF);
        fetch(32'h20, got, lat, ins, sz, npc);
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL 32b_got: got %b want 1", got); end
        n_cmp++; if (lat != 3) begin n_err++; $display("FAIL 32b_lat: got %0d want 3", lat); end
        n_cmp++; if (ins !== 32'h8A0000FF) begin n_err++; $display("FAIL 32b_instr: got %h want 8a0000ff", ins); end
        n_cmp++; if (sz !== 1'b1) begin n_err++; $display("FAIL 32b_size: got %b want 1", sz); end
        n_cmp++; if (npc !== 32'h22) begin n_err++; $display("FAIL 32b_npc: got %h want 00000022", npc); end
    endtask

    task automatic test_wrap();
        bit got; int lat; logic [31:0] ins; logic sz; logic [31:0] npc;
        load(8'hFF, 16'h8001);
        load(8'h00, 16'hBEEF);
        fetch(32'h100000FF, got, lat, ins, sz, npc);
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL wrap_got: got %b want 1", got); end
        n_cmp++; if (ins !== 32'h8001BEEF) begin n_err++; $display("FAIL wrap_instr: got %h want 8001beef", ins); end
        n_cmp++; if (npc !== 32'h10000101) begin n_err++; $display("FAIL wrap_npc: got %h want 10000101", npc); end
    endtask

    task automatic test_flush();
        int seen;
        // Flush during RD1 of the 32-bit fetch at 0x20.
        req_valid = 1'b1; req_addr = 32'h20;
        tick();
        req_valid = 1'b0;
        tick();
        flush = 1'b1;
        #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL flush_rd1_valid: got %b want 0", resp_valid); end
        tick();
        flush = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL flush_rd1_ready: got %b want 1", req_ready); end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid === 1'b1) seen++;
            tick();
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL flush_rd1_pulses: got %0d want 0", seen); end
        n_cmp++; if (resp_instr !== 32'h8001BEEF) begin n_err++; $display("FAIL flush_hold: got %h want 8001beef", resp_instr); end
        // Flush in IDLE blocks acceptance.
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h10;
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL flush_idle_ready: got %b want 0", req_ready); end
        tick();
        flush = 1'b0; req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid === 1'b1) seen++;
            tick();
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL flush_idle_pulses: got %0d want 0", seen); end
        // Flush coinciding with RESP masks the response.
        req_valid = 1'b1; req_addr = 32'h10;
        tick();
        req_valid = 1'b0;
        tick();
        n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL flush_pre_resp: got %b want 1", resp_valid); end
        flush = 1'b1;
        #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL flush_resp_valid: got %b want 0", resp_valid); end
        tick();
        flush = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL flush_resp_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_collision();
        bit got; int lat; logic [31:0] ins; logic sz; logic [31:0] npc;
        load(8'h30, 16'h1111);
        req_valid = 1'b1; req_addr = 32'h30;
        tick();
        req_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 8'h30; ld_data = 16'h2222;
        tick();
        ld_en = 1'b0;
        model_mem[8'h30] = 16'h2222;
        n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL coll_valid: got %b want 1", resp_valid); end
        n_cmp++; if (resp_instr !== 32'h11110000) begin n_err++; $display("FAIL coll_old: got %h want 11110000", resp_instr); end
        fetch(32'h30, got, lat, ins, sz, npc);
        n_cmp++; if (ins !== 32'h22220000) begin n_err++; $display("FAIL coll_new: got %h want 22220000", ins); end
    endtask

    task automatic test_random();
        bit got; int lat; logic [31:0] ins; logic sz; logic [31:0] npc;
        logic [31:0] pc; logic [31:0] e_ins; logic e_sz; logic [31:0] e_npc; int e_lat;
        for (int i = 0; i < 256; i++) load(8'(i), 16'($urandom));
        load(8'hFF, 16'h8000 | 16'($urandom));
        for (int i = 0; i < 40; i++) begin
            pc = (i == 0) ? 32'hFFFFFFFF : $urandom;
            if ($urandom_range(0, 3) == 0) load(8'($urandom), 16'($urandom));
            ref_fetch(pc, e_ins, e_sz, e_npc, e_lat);
            fetch(pc, got, lat, ins, sz, npc);
            n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL rnd_got[%0d]: got %b want 1", i, got); end
            n_cmp++; if (lat != e_lat) begin n_err++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", i, lat, e_lat); end
            n_cmp++; if (ins !== e_ins) begin n_err++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, ins, e_ins); end
            n_cmp++; if (sz !== e_sz) begin n_err++; $display("FAIL rnd_size[%0d]: got %b want %b", i, sz, e_sz); end
            n_cmp++; if (npc !== e_npc) begin n_err++; $display("FAIL rnd_npc[%0d]: got %h want %h", i, npc, e_npc); end
        end
    endtask

    task automatic test_reset_mid();
        bit got; int lat; logic [31:0] ins; logic sz; logic [31:0] npc;
        logic [31:0] pc; logic [31:0] e_ins; logic e_sz; logic [31:0] e_npc; int e_lat;
        logic [31:0] e_vec;
        load(8'h40, 16'h9ABC);
        load(8'h41, 16'h5555);
        req_valid = 1'b1; req_addr = 32'h40;
        tick();
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", resp_valid); end
        n_cmp++; if (resp_instr !== 32'h0) begin n_err++; $display("FAIL mid_instr: got %h want 0", resp_instr); end
        n_cmp++; if (resp_size !== 1'b0) begin n_err++; $display("FAIL mid_size: got %b want 0", resp_size); end
        n_cmp++; if (resp_next_pc !== 32'h0) begin n_err++; $display("FAIL mid_npc: got %h want 0", resp_next_pc); end
        n_cmp++; if (boot_done !== 1'b0) begin n_err++; $display("FAIL mid_boot_done: got %b want 0", boot_done); end
        n_cmp++; if (reset_vec !== 32'h0) begin n_err++; $display("FAIL mid_vec: got %h want 0", reset_vec); end
        n_cmp++; if (req_ready !== !BOOT) begin n_err++; $display("FAIL mid_ready: got %b want %b", req_ready, !BOOT); end
        tick();
        rst_n = 1'b1;
        tick();
        if (BOOT) tick();
        e_vec = BOOT ? {model_mem[0], model_mem[1]} : 32'h0;
        n_cmp++; if (reset_vec !== e_vec) begin n_err++; $display("FAIL mid_reboot_vec: got %h want %h", reset_vec, e_vec); end
        n_cmp++; if (boot_done !== 1'b1) begin n_err++; $display("FAIL mid_reboot_done: got %b want 1", boot_done); end
        pc = 32'h40;
        ref_fetch(pc, e_ins, e_sz, e_npc, e_lat);
        fetch(pc, got, lat, ins, sz, npc);
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL mid_got: got %b want 1", got); end
        n_cmp++; if (lat != e_lat) begin n_err++; $display("FAIL mid_lat: got %0d want %0d", lat, e_lat); end
        n_cmp++; if (ins !== e_ins) begin n_err++; $display("FAIL mid_fetch_instr: got %h want %h", ins, e_ins); end
        n_cmp++; if (npc !== e_npc) begin n_err++; $display("FAIL mid_fetch_npc: got %h want %h", npc, e_npc); end
    endtask

    initial begin
        test_reset();
        test_16bit();
        test_32bit();
        test_wrap();
        test_flush();
        test_collision();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter AW, default 8: halfword address width; the internal array holds 2^AW 16-bit halfwords.
REQ-002 Parameter RD_LAT, default 1, legal range 1..4: clock cycles per halfword read.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1 / req_addr  in  32: fetch request carrying the PC, in halfword units.
REQ-006 req_ready  out  1: request accepted on an edge where req_valid and req_ready are both 1.
REQ-007 flush  in  1: abandons any in-flight request.
REQ-008 resp_valid  out  1 / resp_instr  out  32 / resp_size  out  1 (1 = 32-bit instruction) / resp_next_pc  out  32.
REQ-009 ld_en  in  1 / ld_addr  in  AW / ld_data  in  16: loader write port.
REQ-010 reset_vec  out  32 / boot_done  out  1: boot vector and boot-complete flag.

Function
REQ-011 FSM states BOOT0, BOOT1, IDLE, RD0, RD1, RESP; each read state lasts exactly RD_LAT cycles, tracked by a down-counter.
REQ-012 req_ready shall be 1 only in IDLE with flush=0; on acceptance, latch addr = req_addr[AW-1:0] and pc = req_addr, then go to RD0.
REQ-013 At the end of RD0, capture hw0 = mem[addr]; if hw0[15]=1, go to RD1, else go to RESP.
REQ-014 At the end of RD1, capture hw1 = mem[(addr+1) mod 2^AW] (wrap-around), then go to RESP.
REQ-015 RESP lasts one cycle with resp_valid=1, then the FSM returns to IDLE; there is no back-pressure.
REQ-016 In RESP, resp_instr shall be {hw0,hw1} with resp_size=1 for 32-bit instructions, or {hw0,16'h0000} with resp_size=0 for 16-bit ones.
REQ-017 In RESP, resp_next_pc = pc+2 (32-bit) or pc+1 (16-bit), computed modulo 2^32.
REQ-018 Latency from the acceptance edge to resp_valid high shall be RD_LAT+1 cycles for 16-bit instructions and 2*RD_LAT+1 cycles for 32-bit ones.
REQ-019 In RESP, resp_instr, resp_size and resp_next_pc shall be valid; outside RESP they shall hold their last values.
REQ-020 When flush=1 in RD0, RD1 or RESP, the next state shall be IDLE and resp_valid shall be 0 in that cycle.
REQ-021 When flush=1 in IDLE, the request shall not be accepted.
REQ-022 ld_en writes mem[ld_addr] at the edge in any state, including while reset is asserted.
REQ-023 A read sampling the same address on the same edge as a write shall return the old data.

Reset
REQ-024 Reset asserted, including mid-operation, shall force the state to BOOT0 (or to IDLE when the boot sequence is compiled out) immediately.
REQ-025 Reset shall clear the counter, hw0, hw1, pc, resp_valid, resp_instr, resp_size, resp_next_pc, reset_vec and boot_done to 0.
REQ-026 The memory array shall not be reset.

Configuration
REQ-027 The macro IMEM_BOOT_EN, when defined, compiles in the boot sequence:
- BOOT0 reads mem[0] and BOOT1 reads mem[1].
- reset_vec = {mem[0],mem[1]}, then the FSM enters IDLE.
- boot_done rises on IDLE entry and stays 1 until reset.
- req_ready shall stay 0 during BOOT0 and BOOT1.
REQ-028 Without IMEM_BOOT_EN:
- The BOOT states are absent and reset enters IDLE.
- reset_vec is constantly 0.
- boot_done is 1 from the first clock edge after reset deasserts.

Verification (AW=8, RD_LAT=1)
REQ-029 Boot (IMEM_BOOT_EN defined): ld mem[0]=0x0000 and mem[1]=0x0040 while reset is low, then release reset -> boot_done=1 and reset_vec=0x00000040 after 2 edges.
REQ-030 16-bit: mem[0x10]=0x1234, request 0x10 -> resp_valid 2 cycles later, resp_instr=0x12340000, resp_size=0, resp_next_pc=0x11.
REQ-031 32-bit: mem[0x20]=0x8A00 and mem[0x21]=0x00FF, request 0x20 -> resp_valid after 3 cycles, resp_instr=0x8A0000FF, resp_next_pc=0x22.
REQ-032 Wrap: mem[0xFF]=0x8001 and mem[0x00]=0xBEEF, request 0x100000FF -> resp_instr=0x8001BEEF, resp_next_pc=0x10000101.
REQ-033 Flush: assert flush in RD1 during REQ-031 -> no resp_valid pulse, and req_ready=1 in the next cycle.
REQ-034 Reset mid-RD0 -> all outputs 0 immediately, and after boot a new request completes normally.
